shift_issue_unit: RTL
=====================

// Module: shift_issue_unit
// PURPOSE
//  Two-stage elastic pipeline wrapped around the team's combinational 32-bit right shifter.
//  - Stage A: accepts MIPS shift ops (SLL/SRL/SRA/SLLV/SRLV/SRAV), decodes them and drives the shifter.
//  - Stage B: registers the shifter output as the result.
//  - Left shifts use the right shifter with bit-reversed operand and result.
//  - Sits in EX, between the decode/operand-read stage and writeback.
// PARAMETERS
//  DATA_W    32  operand/result width; must equal 1<<SHFT_LEN
//  SHFT_LEN  5   shift-amount width (matches the shifter's shamt port)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  flush      in   1         sync pipeline kill: drops stage A and stage B contents
//  in_valid   in   1         upstream op valid
//  in_ready   out  1         unit can accept this cycle
//  funct      in   6         MIPS funct field
//  rs_val     in   DATA_W    rs operand; only [SHFT_LEN-1:0] used (variable shifts)
//  rt_val     in   DATA_W    value to shift
//  sa         in   SHFT_LEN  immediate shift amount (SLL/SRL/SRA)
//  sh_x       out  DATA_W    to shifter data input
//  sh_shamt   out  SHFT_LEN  to shifter shift amount
//  sh_arith   out  1         to shifter arithmetic select
//  sh_z       in   DATA_W    from shifter result (combinational)
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts result
//  result     out  DATA_W    shifted value
//  illegal    out  1         funct was not a shift op; qualified by out_valid
// BEHAVIOUR
//  Reset (async, immediate):
//  - a_valid=0, b_valid=0, out_valid=0, result=0, illegal=0.
//  - Stage A regs=0, so sh_x=0, sh_shamt=0, sh_arith=0.
//  Decode (on capture into A):
//  - 000000 SLL:  left,  shamt=sa
//  - 000010 SRL:  right, shamt=sa,  arith=0
//  - 000011 SRA:  right, shamt=sa,  arith=1
//  - 000100 SLLV: left,  shamt=rs_val[4:0]
//  - 000110 SRLV: right, shamt=rs_val[4:0], arith=0
//  - 000111 SRAV: right, shamt=rs_val[4:0], arith=1
//  - Any other funct: ill=1, datapath don't-care; B then captures result=0, illegal=1.
//  Datapath:
//  - Left ops: sh_x=bitrev(rt), sh_arith=0; B captures bitrev(sh_z).
//  - Right ops: sh_x=rt; B captures sh_z.
//  - sh_* driven only from stage A registers (no combinational in->sh path).
//  Handshake (valid/ready, no combinational in_valid->in_ready path):
//  - b_ready   = !b_valid | out_ready
//  - in_ready  = (!a_valid | b_ready) & !flush
//  - Accept when in_valid & in_ready.
//  - A->B transfer when a_valid & b_ready; A and B may update in the same cycle.
//  - out_valid=b_valid.
//  Timing:
//  - Latency: accepted at edge N -> out_valid high after edge N+1; full throughput of 1 op/cycle.
//  - Backpressure: out_ready low holds result/illegal stable; at most 2 ops in flight; order preserved.
//  Flush:
//  - a_valid and b_valid cleared at next edge; no accept that cycle.
//  - Flush wins over simultaneous accept or transfer.
//  - Reset mid-operation discards all in-flight ops; no partial output.
//  shamt=0: result=rt_val for all six ops.
// TESTING
//  1. SRA rt=0x80000000 sa=4 -> result 0xF8000000, illegal=0, out_valid 2 edges after accept.
//  2. SLL rt=0x00000001 sa=31 -> 0x80000000; SLLV rs=0x00000023 rt=0x1 -> 0x00000008.
//  3. SRL rt=0x80000000 sa=4 -> 0x08000000; SRAV rs=0 rt=0x8000_1234 -> 0x80001234.
//  4. 3 back-to-back ops, out_ready=0 for 5 cycles -> 2 held, in_ready=0, results in order, none lost.
//  5. funct=0x20 -> out_valid=1, illegal=1, result=0; flush with valid op in A -> no output emitted.
//  6. rst asserted mid-stream -> out_valid=0 same cycle; in_ready=1 first cycle after release.

Source files
------------

// File: rtl/shift_issue_unit.sv
// Two-stage elastic pipeline around an external combinational right shifter.
// Stage A decodes MIPS shift ops and drives the shifter; stage B holds the result.
module shift_issue_unit #(
    parameter int DATA_W   = 32,
    parameter int SHFT_LEN = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          funct,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    input  logic [SHFT_LEN-1:0] sa,
    output logic [DATA_W-1:0]   sh_x,
    output logic [SHFT_LEN-1:0] sh_shamt,
    output logic                sh_arith,
    input  logic [DATA_W-1:0]   sh_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result,
    output logic                illegal
);

    function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    logic                a_valid;
    logic                a_left;
    logic                a_ill;
    logic                b_valid;
    logic                b_ready;
    logic                accept;
    logic                a_to_b;

    logic                d_left;
    logic                d_arith;
    logic                d_var;
    logic                d_ill;
    logic [SHFT_LEN-1:0] d_shamt;
    logic [DATA_W-1:0]   d_x;

    // Only the low shift-amount bits of rs participate.
    logic unused_rs;
    assign unused_rs = ^rs_val[DATA_W-1:SHFT_LEN];

    always_comb begin
        d_left  = 1'b0;
        d_arith = 1'b0;
        d_var   = 1'b0;
        d_ill   = 1'b0;
        unique case (funct)
            6'b000000: d_left = 1'b1;
            6'b000010: ;
            6'b000011: d_arith = 1'b1;
            6'b000100: begin
                d_left = 1'b1;
                d_var  = 1'b1;
            end
            6'b000110: d_var = 1'b1;
            6'b000111: begin
                d_arith = 1'b1;
                d_var   = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        d_shamt = d_var ? rs_val[SHFT_LEN-1:0] : sa;
        d_x     = d_left ? bitrev(rt_val) : rt_val;
    end

    assign b_ready   = !b_valid || out_ready;
    assign in_ready  = (!a_valid || b_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign a_to_b    = a_valid && b_ready;
    assign out_valid = b_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid  <= 1'b0;
            a_left   <= 1'b0;
            a_ill    <= 1'b0;
            sh_x     <= '0;
            sh_shamt <= '0;
            sh_arith <= 1'b0;
        end else if (flush) begin
            a_valid <= 1'b0;
        end else if (accept) begin
            a_valid  <= 1'b1;
            a_left   <= d_left;
            a_ill    <= d_ill;
            sh_x     <= d_x;
            sh_shamt <= d_shamt;
            sh_arith <= d_arith;
        end else if (a_to_b) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid <= 1'b0;
            result  <= '0;
            illegal <= 1'b0;
        end else if (flush) begin
            b_valid <= 1'b0;
        end else if (a_to_b) begin
            b_valid <= 1'b1;
            illegal <= a_ill;
            if (a_ill)
                result <= '0;
            else if (a_left)
                result <= bitrev(sh_z);
            else
                result <= sh_z;
        end else if (out_ready) begin
            b_valid <= 1'b0;
        end
    end

endmodule
